// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared types and constants for the pipeline hazard / multiplier scheduler.
// No logic, no latency.
// No flow control.
package pipe_hazard_ctl_pkg;

  // Multiplier scheduler states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_e;

  // R-type funct codes; the ID decoder uses them to produce id_is_multu / id_is_mfhilo
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;

  // Multiplier latency from start to valid product
  localparam int MUL_CYCLES_DEF = 32;

endpackage

// File: rtl/pipe_hazard_ctl_mul_sched.sv
// Multi-cycle multiplier scheduler: start pulse, busy window, HI/LO capture strobe.
// Latency: start at T, busy T+1..T+MUL_CYCLES, hilo_load at T+MUL_CYCLES.
// No backpressure; a start request while running is ignored (hazard logic prevents it).
module mul_sched
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ex_is_multu,
  output logic o_mul_start,
  output logic o_mul_busy,
  output logic o_hilo_load
);

  localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  mul_state_e       r_state;
  mul_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // State and countdown registers; reset returns to IDLE and abandons any product in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and strobes; reset masks the one-cycle pulses in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_mul_start = 1'b0;
    o_mul_busy  = 1'b0;
    o_hilo_load = 1'b0;
    case (r_state)
      IDLE: begin
        o_mul_start = i_ex_is_multu & ~i_rst;
        if (i_ex_is_multu) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = LP_CNT_LOAD;
        end
      end
      RUN: begin
        o_mul_busy = 1'b1;
        if (r_cnt == '0) begin
          o_hilo_load = ~i_rst;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard detection for load-use and HI/LO conflicts plus multiplier ownership.
// Latency: stall/enables are combinational (0 cycles); stall counter updates next edge.
// Stall freezes PC and IF/ID and injects a bubble into ID/EX; no other backpressure.
module pipe_hazard_ctl
  import pipe_hazard_ctl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_is_multu,
  input  logic        id_is_mfhilo,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_is_multu,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_bubble,
  output logic        mul_start,
  output logic        mul_busy,
  output logic        hilo_load,
  output logic [15:0] stall_cycles
);

  logic        w_mul_busy;
  logic        w_load_use;
  logic        w_hilo_haz;
  logic        w_mul_struct;
  logic        w_stall;
  logic [15:0] r_stall_cycles;

  mul_sched #(
    .MUL_CYCLES (MUL_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mul_sched (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ex_is_multu (ex_is_multu),
    .o_mul_start   (mul_start),
    .o_mul_busy    (w_mul_busy),
    .o_hilo_load   (hilo_load)
  );

  // Load in EX writing a register the ID instruction reads; $zero never creates a hazard
  assign w_load_use = ex_mem_read & (ex_rt != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

  // MFHI/MFLO must wait until the product has been captured into HI/LO
  assign w_hilo_haz = id_is_mfhilo & (w_mul_busy | ex_is_multu);

  // Only one multiply can be in flight; a following MULTU waits in ID
  assign w_mul_struct = id_is_multu & (w_mul_busy | ex_is_multu);

  assign w_stall      = w_load_use | w_hilo_haz | w_mul_struct;
  assign pc_en        = ~w_stall;
  assign ifid_en      = ~w_stall;
  assign idex_bubble  = w_stall;
  assign mul_busy     = w_mul_busy;
  assign stall_cycles = r_stall_cycles;

  // Saturating count of stalled cycles; simultaneous hazards count once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 16'd0;
    end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
module tb_pipe_hazard_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, id_is_multu, id_is_mfhilo;
  logic        ex_mem_read, ex_is_multu;
  logic        pc_en, ifid_en, idex_bubble, mul_start, mul_busy, hilo_load;
  logic [15:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctl #(.MUL_CYCLES(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_multu  (id_is_multu),
    .id_is_mfhilo (id_is_mfhilo),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .ex_is_multu  (ex_is_multu),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_bubble  (idex_bubble),
    .mul_start    (mul_start),
    .mul_busy     (mul_busy),
    .hilo_load    (hilo_load),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // A MULTU reaching EX while the multiplier runs is a protocol error
  always @(negedge clk) begin
    if (!rst && mul_busy && ex_is_multu) begin
      errors++;
      $display("FAIL protocol: ex_is_multu=1 while mul_busy=1 at %0t", $time);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_multu = 1'b0; id_is_mfhilo = 1'b0;
    ex_mem_read = 1'b0; ex_is_multu = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    ex_is_multu = 1'b1;  // start request during reset must be masked
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL rst_pc_en got=%b exp=1", pc_en); end
    checks++; if (ifid_en !== 1'b1) begin errors++; $display("FAIL rst_ifid_en got=%b exp=1", ifid_en); end
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble got=%b exp=0", idex_bubble); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start got=%b exp=0", mul_start); end
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL rst_mul_busy got=%b exp=0", mul_busy); end
    checks++; if (hilo_load !== 1'b0) begin errors++; $display("FAIL rst_hilo_load got=%b exp=0", hilo_load); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_stall_cycles got=%0d exp=0", stall_cycles); end
    tick();
    ex_is_multu = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL rst_no_run got=%b exp=0", mul_busy); end
  endtask

  task automatic test_load_use();
    do_reset();
    // lw $t0 in EX, add reading $t0 via rs in ID
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL lu_pc_en got=%b exp=0", pc_en); end
    checks++; if (ifid_en !== 1'b0) begin errors++; $display("FAIL lu_ifid_en got=%b exp=0", ifid_en); end
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%b exp=1", idex_bubble); end
    tick();
    ex_mem_read = 1'b0; ex_rt = 5'd0;  // bubble now in EX
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL lu_release got=%b exp=1", pc_en); end
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_cycles); end
    // rt operand match
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_uses_rs = 1'b1; id_rt = 5'd9; id_uses_rt = 1'b1;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL lu_rt got=%b exp=1", idex_bubble); end
    // matching field that the instruction does not read
    id_uses_rt = 1'b0;
    #1;
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL lu_unused got=%b exp=0", idex_bubble); end
    // load to $zero never stalls
    ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL lu_zero got=%b exp=1", pc_en); end
    tick();
    #1;
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_zero_count got=%0d exp=1", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_multu();
    int bad_busy, bad_hilo, bad_start;
    do_reset();
    ex_is_multu = 1'b1;
    #1;
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL mul_start_T got=%b exp=1", mul_start); end
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL mul_busy_T got=%b exp=0", mul_busy); end
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL mul_no_stall got=%b exp=1", pc_en); end
    bad_busy = 0; bad_hilo = 0; bad_start = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      ex_is_multu = 1'b0;
      #1;
      if (mul_busy !== 1'b1) bad_busy++;
      if (hilo_load !== (k == 32)) bad_hilo++;
      if (mul_start !== 1'b0) bad_start++;
    end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL mul_busy_window bad_cycles=%0d exp=0", bad_busy); end
    checks++; if (bad_hilo != 0) begin errors++; $display("FAIL mul_hilo_timing bad_cycles=%0d exp=0", bad_hilo); end
    checks++; if (bad_start != 0) begin errors++; $display("FAIL mul_start_pulse bad_cycles=%0d exp=0", bad_start); end
    tick();
    #1;
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL mul_idle_T33 got=%b exp=0", mul_busy); end
    checks++; if (hilo_load !== 1'b0) begin errors++; $display("FAIL mul_hilo_T33 got=%b exp=0", hilo_load); end
  endtask

  task automatic test_mfhi();
    int bad;
    do_reset();
    ex_is_multu = 1'b1; id_is_mfhilo = 1'b1;
    bad = 0;
    #1;
    if (pc_en !== 1'b0) bad++;
    for (int k = 1; k <= 32; k++) begin
      tick();
      ex_is_multu = 1'b0;
      #1;
      if (pc_en !== 1'b0 || idex_bubble !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mfhi_stall_window bad_cycles=%0d exp=0", bad); end
    tick();
    #1;
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL mfhi_release got=%b exp=1", pc_en); end
    checks++; if (stall_cycles !== 16'd33) begin errors++; $display("FAIL mfhi_count got=%0d exp=33", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int bad, hilo_seen;
    do_reset();
    ex_is_multu = 1'b1; id_is_multu = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL b2b_struct_T got=%b exp=0", pc_en); end
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      ex_is_multu = 1'b0;
      #1;
      if (pc_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_stall_window bad_cycles=%0d exp=0", bad); end
    tick();  // T+33: second MULTU now in EX
    id_is_multu = 1'b0; ex_is_multu = 1'b1;
    #1;
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL b2b_start_T33 got=%b exp=1", mul_start); end
    checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL b2b_release got=%b exp=1", pc_en); end
    hilo_seen = -1;
    for (int k = 34; k <= 66; k++) begin
      tick();
      ex_is_multu = 1'b0;
      #1;
      if (hilo_load === 1'b1 && hilo_seen < 0) hilo_seen = k;
    end
    checks++; if (hilo_seen != 65) begin errors++; $display("FAIL b2b_hilo_cycle got=T+%0d exp=T+65", hilo_seen); end
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", mul_busy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ex_is_multu = 1'b1;
    tick();
    ex_is_multu = 1'b0;
    // load-use and HI/LO hazard together
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; id_is_mfhilo = 1'b1;
    #1;
    checks++; if (idex_bubble !== 1'b1) begin errors++; $display("FAIL sim_bubble got=%b exp=1", idex_bubble); end
    tick();
    clear_inputs();
    #1;
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL sim_count got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_reset_mid_run();
    int hilo_cnt;
    do_reset();
    ex_is_multu = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      ex_is_multu = 1'b0;
    end
    rst = 1'b1;  // cycle T+10
    #1;
    checks++; if (hilo_load !== 1'b0) begin errors++; $display("FAIL mrst_hilo got=%b exp=0", hilo_load); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got=%b exp=0", mul_busy); end
    checks++; if (pc_en !== 1'b1 || ifid_en !== 1'b1 || idex_bubble !== 1'b0)
      begin errors++; $display("FAIL mrst_enables got=%b%b%b exp=110", pc_en, ifid_en, idex_bubble); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL mrst_count got=%0d exp=0", stall_cycles); end
    hilo_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (hilo_load === 1'b1 || mul_busy === 1'b1) hilo_cnt++;
      tick();
    end
    checks++; if (hilo_cnt != 0) begin errors++; $display("FAIL mrst_no_hilo got=%0d exp=0", hilo_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    for (int k = 0; k < 65534; k++) tick();
    checks++; if (stall_cycles !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=fffe", stall_cycles); end
    tick();
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_hit got=%h exp=ffff", stall_cycles); end
    for (int k = 0; k < 4465; k++) tick();
    checks++; if (stall_cycles !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_multu();
    test_mfhi();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_run();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
